instruction_fetch_unit: RTL

- Multi-cycle fetch stage of the MIPS datapath.
- Holds the PC, requests instruction words from memory over a MOV/MOC-style handshake, and latches each word into the instruction register (IR).
- Presents IR plus a pre-decoded 2-bit extend/shift select to the immediate sign-extender and decode logic, which sit directly downstream.
- Handles PC redirects (branch/jump) and flushes.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/instruction_fetch_unit_if.sv | 10 +
 rtl/instruction_fetch_unit_sse_decoder.sv | 20 ++
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-stage types, sse encodings and opcode constants
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } fetch_state_t;

    localparam logic [1:0] SSE_SEXT16     = 2'b00;
    localparam logic [1:0] SSE_SEXT16_SL2 = 2'b01;
    localparam logic [1:0] SSE_IMM26_SL2  = 2'b10;
    localparam logic [1:0] SSE_ZERO       = 2'b11;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - MOV/MOC instruction memory read port
interface instruction_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_moc;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_moc, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_moc, mem_rdata);
endinterface

// File: rtl/instruction_fetch_unit_sse_decoder.sv
// rtl/instruction_fetch_unit_sse_decoder.sv - opcode to extend/shift select decode
module sse_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [1:0] sse
);

    always_comb begin
        sse = SSE_SEXT16;
        case (opcode)
            OP_J, OP_JAL:                         sse = SSE_IMM26_SL2;
            OP_REGIMM, OP_BEQ, OP_BNE,
            OP_BLEZ, OP_BGTZ:                     sse = SSE_SEXT16_SL2;
            OP_RTYPE:                             sse = SSE_ZERO;
            default:                              sse = SSE_SEXT16;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - multi-cycle fetch stage: PC, memory handshake and IR
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  mem,
    input  logic                      fetch_en,
    input  logic                      pc_load,
    input  logic [31:0]               pc_load_value,
    output logic [31:0]               ir,
    output logic                      ir_valid,
    input  logic                      ir_ack,
    output logic [1:0]                sse,
    output logic [31:0]               pc_plus4,
    output logic                      fetch_err
);

    localparam logic [7:0] CNT_LAST = 8'(WAIT_LIMIT - 1);

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d, ir_q, ir_d, pc_plus4_q, pc_plus4_d, pend_val, pend_val_d;
    logic [1:0]   sse_q, sse_d, dec_sse;
    logic [7:0]   cnt, cnt_d;
    logic         err_q, err_d, pend, pend_d, gap, gap_d;

    sse_decoder u_sse_decoder (
        .opcode (mem.mem_rdata[31:26]),
        .sse    (dec_sse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ir_q       <= 32'h0;
            sse_q      <= SSE_ZERO;
            pc_plus4_q <= RESET_PC;
            err_q      <= 1'b0;
            cnt        <= 8'd0;
            pend       <= 1'b0;
            pend_val   <= 32'h0;
            gap        <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            ir_q       <= ir_d;
            sse_q      <= sse_d;
            pc_plus4_q <= pc_plus4_d;
            err_q      <= err_d;
            cnt        <= cnt_d;
            pend       <= pend_d;
            pend_val   <= pend_val_d;
            gap        <= gap_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        ir_d       = ir_q;
        sse_d      = sse_q;
        pc_plus4_d = pc_plus4_q;
        err_d      = err_q;
        cnt_d      = cnt;
        pend_d     = pend;
        pend_val_d = pend_val;
        gap_d      = 1'b0;
        case (state)
            IDLE: begin
                if (pc_load) pc_d = pc_load_value;
                if (fetch_en && !err_q) state_d = FETCH;
            end
            FETCH: begin
                if (gap) begin
                    // No request is outstanding during the gap, so a redirect applies directly.
                    if (pc_load) pc_d = pc_load_value;
                end else if (mem.mem_moc) begin
                    cnt_d = 8'd0;
                    if (pend || pc_load) begin
                        pc_d   = pc_load ? pc_load_value : pend_val;
                        pend_d = 1'b0;
                        gap_d  = 1'b1;
                    end else begin
                        ir_d       = mem.mem_rdata;
                        sse_d      = dec_sse;
                        pc_d       = pc + 32'd4;
                        pc_plus4_d = pc + 32'd4;
                        state_d    = VALID;
                    end
                end else begin
                    if (pc_load) begin
                        pend_d     = 1'b1;
                        pend_val_d = pc_load_value;
                    end
                    if (cnt == CNT_LAST) begin
                        err_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                        if (pc_load || pend) begin
                            pc_d   = pc_load ? pc_load_value : pend_val;
                            pend_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt + 8'd1;
                    end
                end
            end
            VALID: begin
                if (pc_load) begin
                    pc_d    = pc_load_value;
                    state_d = fetch_en ? FETCH : IDLE;
                end else if (ir_ack) begin
                    state_d = fetch_en ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem.mem_req  = (state == FETCH) && !gap;
    assign mem.mem_addr = pc;
    assign ir_valid     = (state == VALID);
    assign ir           = ir_q;
    assign sse          = sse_q;
    assign pc_plus4     = pc_plus4_q;
    assign fetch_err    = err_q;

endmodule
